// File: rtl/serial_subtractor_if.sv
// Start/operand request and busy/done/result response of the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first.
// state | meaning
// IDLE  | waiting for start; last result held on d/bout/ovf
// SHIFT | processing bit cnt_q of the operands
// DONE  | one-cycle result strobe; start here chains the next operation
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             x_bit;
  logic             y_bit;
  logic             diff_bit;
  logic             brw_next;
  logic             last_bit;

  always_comb begin
    x_bit    = a_sr_q[0];
    y_bit    = b_sr_q[0];
    diff_bit = x_bit ^ y_bit ^ brw_q;
    brw_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & brw_q);
    last_bit = (cnt_q == LAST_BIT);
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (bus.start) begin
          state_d = SHIFT;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          brw_d   = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
        end
      end

      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        brw_d  = brw_next;
        // Partial result keeps only the low WIDTH-1 bits; the MSB is the live diff bit.
        res_d  = (WIDTH-1)'({diff_bit, res_q} >> 1);
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = DONE;
          cnt_d   = '0;
          d_d     = {diff_bit, res_q};
          bout_d  = brw_next;
          ovf_d   = (x_bit != y_bit) && (diff_bit != x_bit);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_d_last;
  logic         exp_bout_last;
  logic         exp_ovf_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction, unsigned for borrow, signed range for overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                output logic [W-1:0] d, output logic bout, output logic ovf);
    longint ua, ub, sa, sb, ud, sd;
    ua   = longint'(a);
    ub   = longint'(b);
    ud   = ua - ub - longint'(bin);
    d    = W'(ud);
    bout = (ud < 0);
    sa   = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb   = b[W-1] ? ub - (longint'(1) << W) : ub;
    sd   = sa - sb - longint'(bin);
    ovf  = (sd < -(longint'(1) << (W-1))) || (sd > (longint'(1) << (W-1)) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_operands();
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.bin = 1'($urandom);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ed, input logic eb, input logic eo);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_d"},    bus.d,    ed);
    check({tag, "_bout"}, bus.bout, eb);
    check({tag, "_ovf"},  bus.ovf,  eo);
    exp_d_last    = ed;
    exp_bout_last = eb;
    exp_ovf_last  = eo;
  endtask

  // One operation; repulse_at >= 0 raises start with junk operands in that SHIFT cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input int repulse_at);
    logic [W-1:0] ed;
    logic         eb, eo;
    model(a, b, bin, ed, eb, eo);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    tick();
    for (int i = 0; i < W; i++) begin
      check("shift_busy", bus.busy, 1);
      check("shift_done", bus.done, 0);
      check("shift_d_hold", bus.d, exp_d_last);
      scramble_operands();
      bus.start = (i == repulse_at);
      tick();
    end
    bus.start = 1'b0;
    check_result("op", ed, eb, eo);
    tick();
    check("done_single", bus.done, 0);
    check("idle_d_hold", bus.d, exp_d_last);
    check("idle_bout_hold", bus.bout, exp_bout_last);
    check("idle_ovf_hold", bus.ovf, exp_ovf_last);
  endtask

  task automatic run_b2b(input logic [3*W-1:0] av, input logic [3*W-1:0] bv, input logic [2:0] binv);
    logic [W-1:0] ed;
    logic         eb, eo;
    bus.start = 1'b1;
    bus.a     = av[W-1:0];
    bus.b     = bv[W-1:0];
    bus.bin   = binv[0];
    tick();
    for (int k = 0; k < 3; k++) begin
      model(av[k*W +: W], bv[k*W +: W], binv[k], ed, eb, eo);
      for (int i = 0; i < W; i++) begin
        check("b2b_busy", bus.busy, 1);
        check("b2b_done_early", bus.done, 0);
        scramble_operands();
        tick();
      end
      check_result("b2b", ed, eb, eo);
      if (k < 2) begin
        bus.a   = av[(k+1)*W +: W];
        bus.b   = bv[(k+1)*W +: W];
        bus.bin = binv[k+1];
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    check("b2b_end_done", bus.done, 0);
    check("b2b_end_busy", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_d",    bus.d,    0);
    check("rst_bout", bus.bout, 0);
    check("rst_ovf",  bus.ovf,  0);
    rst           = 1'b0;
    exp_d_last    = '0;
    exp_bout_last = 1'b0;
    exp_ovf_last  = 1'b0;

    run_op(8'h05, 8'h03, 1'b0, -1);
    run_op(8'h00, 8'h01, 1'b0, -1);
    run_op(8'h10, 8'h0F, 1'b1, -1);
    run_op(8'h80, 8'h01, 1'b0, -1);
    run_op(8'h7F, 8'hFF, 1'b0, -1);
    run_op(8'h5A, 8'h5A, 1'b0, -1);
    run_op(8'h00, 8'h00, 1'b1, -1);
    run_op(8'h33, 8'h11, 1'b0, 3);

    // Abort in the middle of SHIFT.
    bus.start = 1'b1;
    bus.a     = 8'hC3;
    bus.b     = 8'h21;
    bus.bin   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_busy", bus.busy, 1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy0", bus.busy, 0);
    check("abort_done0", bus.done, 0);
    check("abort_d0",    bus.d,    0);
    check("abort_bout0", bus.bout, 0);
    check("abort_ovf0",  bus.ovf,  0);
    exp_d_last    = '0;
    exp_bout_last = 1'b0;
    exp_ovf_last  = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      check("abort_no_done", bus.done, 0);
      tick();
    end
    run_op(8'h44, 8'h45, 1'b0, -1);

    // Reset wins over start; start right after release is accepted.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h99;
    bus.b     = 8'h11;
    tick();
    check("prio_busy", bus.busy, 0);
    check("prio_d",    bus.d,    0);
    exp_d_last    = '0;
    exp_bout_last = 1'b0;
    exp_ovf_last  = 1'b0;
    rst = 1'b0;
    run_op(8'h99, 8'h11, 1'b0, -1);

    run_b2b({8'hFF, 8'h01, 8'hC8}, {8'hFF, 8'h02, 8'h37}, 3'b101);

    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 20)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
